// File: rtl/tt_um_seq_divider.sv
// -----------------------------------------------------------------------------
// tt_um_seq_divider
//   Iterative restoring divider wrapped as a Tiny Tapeout user top. Operands
//   are loaded a byte at a time over ui_in; one quotient bit is resolved per
//   clock. The result (quotient or remainder) is muxed onto uo_out.
//
//   Optional feature macro: SEQ_DIV_SIGNED_EN
//     Defined   : uio_in[4] selects two's-complement division at start.
//     Undefined : all division is unsigned, uio_in[4] is ignored.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   ena      in   power-good from the harness, ignored
//   ui_in    in   [7:0] operand byte
//   uio_in   in   [0] ld_dvd [1] ld_dvs [2] start [3] sel (0=q, 1=r)
//                 [4] signed_mode (signed build only) [7:5] unused
//   uo_out   out  sel ? remainder : quotient
//   uio_out  out  [7] busy [6] done [5] div_by_zero [4:0] 0
//   uio_oe   out  constant 8'hE0 (upper three uio pins are outputs)
//
// WIDTH is the core width; the pin mapping assumes WIDTH = 8.
// -----------------------------------------------------------------------------
module tt_um_seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] dividend_reg, divisor_reg;
   logic [WIDTH-1:0] quotient_reg, remainder_reg;
   logic [WIDTH-1:0] work_rem, work_q;
   logic [CW-1:0]    cnt;
   logic             dbz;

   // control decode
   logic ld_dvd, ld_dvs, start, sel;
   assign ld_dvd = uio_in[0];
   assign ld_dvs = uio_in[1];
   assign start  = uio_in[2];
   assign sel    = uio_in[3];

   logic idle_like, go, dvs_zero, last_step;
   assign idle_like = (state != RUN);
   // a load in the same cycle wins over start; the start is dropped
   assign go        = idle_like && start && !ld_dvd && !ld_dvs;
   assign dvs_zero  = (divisor_reg == '0);
   assign last_step = (state == RUN) && (cnt == CW'(1));

   // operand magnitudes and final sign correction
   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic [WIDTH-1:0] step_rem, step_q;
   logic [WIDTH-1:0] q_fix, r_fix;

`ifdef SEQ_DIV_SIGNED_EN
   logic sgn_mode;
   logic sgn_run, neg_q, neg_r;
   assign sgn_mode = uio_in[4];
   // -128 maps to magnitude 128, which still fits WIDTH bits unsigned
   assign dvd_mag  = (sgn_mode && dividend_reg[WIDTH-1]) ? -dividend_reg : dividend_reg;
   assign dvs_mag  = (sgn_run  && divisor_reg[WIDTH-1])  ? -divisor_reg  : divisor_reg;
   assign q_fix    = neg_q ? -step_q   : step_q;
   assign r_fix    = neg_r ? -step_rem : step_rem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sgn_run <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
      end else if (go) begin
         sgn_run <= sgn_mode;
         neg_q   <= sgn_mode && (dividend_reg[WIDTH-1] ^ divisor_reg[WIDTH-1]);
         neg_r   <= sgn_mode && dividend_reg[WIDTH-1];
      end
   end

   logic unused_sig;
   assign unused_sig = &{1'b0, ena, uio_in[7:5]};
`else
   assign dvd_mag = dividend_reg;
   assign dvs_mag = divisor_reg;
   assign q_fix   = step_q;
   assign r_fix   = step_rem;

   logic unused_sig;
   assign unused_sig = &{1'b0, ena, uio_in[7:4]};
`endif

   // one restoring step: shift {rem,q} left, try subtracting the divisor.
   // The shifted remainder needs WIDTH+1 bits; one extra bit holds the borrow.
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] trial;
   logic             ge;
   assign rem_sh   = {work_rem, work_q[WIDTH-1]};
   assign trial    = {1'b0, rem_sh} - {2'b00, dvs_mag};
   assign ge       = ~trial[WIDTH+1];
   // when the trial fails rem_sh < divisor, so its low WIDTH bits are exact
   assign step_rem = ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   assign step_q   = {work_q[WIDTH-2:0], ge};

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (go) state_nxt = dvs_zero ? DONE : RUN;
         end
         RUN: begin
            if (last_step) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dividend_reg  <= '0;
         divisor_reg   <= '0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         work_rem      <= '0;
         work_q        <= '0;
         cnt           <= '0;
         dbz           <= 1'b0;
      end else begin
         if (idle_like) begin
            if (ld_dvd) dividend_reg <= WIDTH'(ui_in);
            if (ld_dvs) divisor_reg  <= WIDTH'(ui_in);
         end

         if (go) begin
            dbz <= dvs_zero;
            if (dvs_zero) begin
               // zero divisor resolves in one cycle, always unsigned
               quotient_reg  <= '1;
               remainder_reg <= dividend_reg;
            end else begin
               work_rem <= '0;
               work_q   <= dvd_mag;
               cnt      <= CW'(WIDTH);
            end
         end

         if (state == RUN) begin
            work_rem <= step_rem;
            work_q   <= step_q;
            cnt      <= cnt - CW'(1);
            // results only move on DONE entry, so they hold through RUN
            if (last_step) begin
               quotient_reg  <= q_fix;
               remainder_reg <= r_fix;
            end
         end
      end
   end

   // outputs
   logic busy, done;
   assign busy = (state == RUN);
   assign done = (state == DONE);

   assign uo_out  = 8'(sel ? remainder_reg : quotient_reg);
   assign uio_out = {busy, done, dbz, 5'b00000};
   assign uio_oe  = 8'hE0;

endmodule
